exunit_custom_pipe: RTL

Parametrised, fully pipelined custom-op execution unit for the out-of-order core. It sits beside the ALU/MUL units behind its reservation station.
- Computes one of eight bit-manipulation/min-max ops.
- Carries the result, RRF tag and speculation state through LATENCY register stages.
- Writes back to the RRF/ROB.
- Squashes in-flight ops on branch mispredict and clears speculation on correct prediction.

---
 rtl/exunit_custom_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/exunit_custom_pipe.sv
// Pipelined custom-op execution unit: bit-count/byte-reverse/min-max ops carried through
// LATENCY stages with branch squash and speculation clear. Optional counters: EXUNIT_CUSTOM_STAT_EN.
module exunit_custom_pipe #(
    parameter int DATA_LEN    = 32,
    parameter int LATENCY     = 2,
    parameter int SPECTAG_LEN = 5,
    parameter int RRF_SEL     = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue,
    input  logic [DATA_LEN-1:0]    ex_src1,
    input  logic [DATA_LEN-1:0]    ex_src2,
    input  logic [DATA_LEN-1:0]    imm,
    input  logic                   src_b_sel,
    input  logic [2:0]             funct3,
    input  logic                   dstval,
    input  logic [RRF_SEL-1:0]     rrftag,
    input  logic [SPECTAG_LEN-1:0] spectag,
    input  logic                   specbit,
    input  logic                   prmiss,
    input  logic                   prsuccess,
    input  logic [SPECTAG_LEN-1:0] spectagfix,
    output logic [DATA_LEN-1:0]    result,
    output logic [RRF_SEL-1:0]     result_rrftag,
    output logic                   rrf_we,
    output logic                   rob_we,
    output logic                   kill_speculative
`ifdef EXUNIT_CUSTOM_STAT_EN
    ,
    output logic [31:0]            stat_done,
    output logic [31:0]            stat_killed
`endif
);

    function automatic logic tag_hit(input logic [SPECTAG_LEN-1:0] tag,
                                     input logic [SPECTAG_LEN-1:0] fix);
        return |(tag & fix);
    endfunction

    logic [DATA_LEN-1:0] src_b;
    logic [DATA_LEN-1:0] op_result;

    assign src_b = src_b_sel ? imm : ex_src2;

    always_comb begin
        op_result = '0;
        case (funct3)
            3'b000: begin
                for (int i = 0; i < DATA_LEN; i++)
                    op_result = op_result + DATA_LEN'(ex_src1[i]);
            end
            3'b001: begin
                op_result = DATA_LEN'(DATA_LEN);
                for (int i = 0; i < DATA_LEN; i++)
                    if (ex_src1[i]) op_result = DATA_LEN'(DATA_LEN - 1 - i);
            end
            3'b010: begin
                op_result = DATA_LEN'(DATA_LEN);
                for (int i = DATA_LEN - 1; i >= 0; i--)
                    if (ex_src1[i]) op_result = DATA_LEN'(i);
            end
            3'b011: begin
                for (int i = 0; i < DATA_LEN / 8; i++)
                    op_result[8*i +: 8] = ex_src1[DATA_LEN-8-8*i +: 8];
            end
            3'b100: op_result = ($signed(ex_src1) < $signed(src_b)) ? ex_src1 : src_b;
            3'b101: op_result = ($signed(ex_src1) > $signed(src_b)) ? ex_src1 : src_b;
            3'b110: op_result = (ex_src1 < src_b) ? ex_src1 : src_b;
            3'b111: op_result = (ex_src1 > src_b) ? ex_src1 : src_b;
        endcase
    end

    // Index 0 is stage 1; index LATENCY-1 drives the writeback outputs.
    logic [LATENCY-1:0]     st_valid, st_dst, st_specbit, stg_kill;
    logic [DATA_LEN-1:0]    st_result  [LATENCY];
    logic [RRF_SEL-1:0]     st_rrftag  [LATENCY];
    logic [SPECTAG_LEN-1:0] st_spectag [LATENCY];

    logic [LATENCY-1:0]     nxt_valid, nxt_dst, nxt_specbit;
    logic [DATA_LEN-1:0]    nxt_result  [LATENCY];
    logic [RRF_SEL-1:0]     nxt_rrftag  [LATENCY];
    logic [SPECTAG_LEN-1:0] nxt_spectag [LATENCY];

    // prmiss wins over a (illegal) simultaneous prsuccess, so specbit is only cleared without prmiss.
    logic clr_spec;
    assign clr_spec = prsuccess & ~prmiss;

    assign kill_speculative = issue & specbit & prmiss & tag_hit(spectag, spectagfix);

    always_comb begin
        for (int i = 0; i < LATENCY; i++)
            stg_kill[i] = prmiss & st_specbit[i] & tag_hit(st_spectag[i], spectagfix);
    end

    always_comb begin
        nxt_valid      = '0;
        nxt_dst        = '0;
        nxt_specbit    = '0;
        nxt_result[0]  = op_result;
        nxt_rrftag[0]  = rrftag;
        nxt_spectag[0] = spectag;
        nxt_valid[0]   = issue & ~kill_speculative;
        nxt_dst[0]     = dstval;
        nxt_specbit[0] = specbit & ~(clr_spec & tag_hit(spectag, spectagfix));
        for (int i = 1; i < LATENCY; i++) begin
            nxt_result[i]  = st_result[i-1];
            nxt_rrftag[i]  = st_rrftag[i-1];
            nxt_spectag[i] = st_spectag[i-1];
            nxt_dst[i]     = st_dst[i-1];
            nxt_valid[i]   = st_valid[i-1] & ~stg_kill[i-1];
            nxt_specbit[i] = st_specbit[i-1] & ~(clr_spec & tag_hit(st_spectag[i-1], spectagfix));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_valid   <= '0;
            st_dst     <= '0;
            st_specbit <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                st_result[i]  <= '0;
                st_rrftag[i]  <= '0;
                st_spectag[i] <= '0;
            end
        end else begin
            st_valid   <= nxt_valid;
            st_dst     <= nxt_dst;
            st_specbit <= nxt_specbit;
            for (int i = 0; i < LATENCY; i++) begin
                st_result[i]  <= nxt_result[i];
                st_rrftag[i]  <= nxt_rrftag[i];
                st_spectag[i] <= nxt_spectag[i];
            end
        end
    end

    assign rob_we        = st_valid[LATENCY-1] & ~stg_kill[LATENCY-1];
    assign rrf_we        = rob_we & st_dst[LATENCY-1];
    assign result        = st_result[LATENCY-1];
    assign result_rrftag = st_rrftag[LATENCY-1];

`ifdef EXUNIT_CUSTOM_STAT_EN
    logic [31:0] kill_cnt;

    always_comb begin
        kill_cnt = 32'(kill_speculative);
        for (int i = 0; i < LATENCY; i++)
            kill_cnt = kill_cnt + 32'(st_valid[i] & stg_kill[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_done   <= '0;
            stat_killed <= '0;
        end else begin
            if (rob_we) stat_done <= stat_done + 32'd1;
            stat_killed <= stat_killed + kill_cnt;
        end
    end
`endif

endmodule
